ahb_lite_subordinate_bpif: RTL and testbench

//   AHB-Lite subordinate front end that drives the protocol side of bus_protocol_if.

---
 rtl/ahb_lite_subordinate_bpif_if.sv | 31 +++
 rtl/ahb_lite_subordinate_bpif.sv | 154 +++++++++++++++
 tb/tb_ahb_lite_subordinate_bpif.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_subordinate_bpif_if.sv
// Request/response handshake between a bus front end and a peripheral register block.
// The protocol side issues wen/ren beats; the peripheral answers with stall, error and read data.
interface bus_protocol_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    wen;
    logic                    ren;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] strobe;
    logic                    is_burst;
    logic [1:0]              burst_type;
    logic [4:0]              burst_length;
    logic                    secure_transfer;
    logic                    request_stall;
    logic                    error;
    logic [DATA_WIDTH-1:0]   rdata;

    modport protocol (
        output wen, ren, addr, wdata, strobe,
        output is_burst, burst_type, burst_length, secure_transfer,
        input  request_stall, error, rdata
    );

    modport peripheral (
        input  wen, ren, addr, wdata, strobe,
        input  is_burst, burst_type, burst_length, secure_transfer,
        output request_stall, error, rdata
    );
endinterface

// File: rtl/ahb_lite_subordinate_bpif.sv
// AHB-Lite subordinate that turns pipelined address/data phases into one wen/ren beat per
// data phase, mapping peripheral stall to wait states and peripheral error to an ERROR response.
module ahb_lite_subordinate_bpif #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    bus_protocol_if.protocol      bpif
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LG     = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} state_t;

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [STRB_W-1:0]     strobe_q, strobe_d;
    logic                  is_burst_q, is_burst_d;
    logic [1:0]            burst_type_q, burst_type_d;
    logic [4:0]            burst_length_q, burst_length_d;

    logic                  accept, take, legal, wen, ren;
    logic [31:0]           off, nbytes;
    logic [STRB_W-1:0]     strb_new;
    logic [1:0]            btype_new;
    logic [4:0]            blen_new;

    assign accept = HSEL && HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11);

    // Address-phase decode: byte lane offset, size legality/alignment, strobe and burst hints.
    always_comb begin
        off      = 32'(HADDR) & 32'(STRB_W - 1);
        nbytes   = 32'd1 << HSIZE;
        legal    = (32'(HSIZE) <= 32'(LG)) && ((off & (nbytes - 32'd1)) == 32'd0);
        strb_new = '0;
        for (int i = 0; i < STRB_W; i++)
            strb_new[i] = (32'(i) >= off) && (32'(i) < off + nbytes);
        btype_new = 2'b00;
        blen_new  = 5'd1;
        case (HBURST)
            3'd0: begin btype_new = 2'b00; blen_new = 5'd1;  end
            3'd1: begin btype_new = 2'b01; blen_new = 5'd0;  end
            3'd2: begin btype_new = 2'b10; blen_new = 5'd4;  end
            3'd3: begin btype_new = 2'b01; blen_new = 5'd4;  end
            3'd4: begin btype_new = 2'b10; blen_new = 5'd8;  end
            3'd5: begin btype_new = 2'b01; blen_new = 5'd8;  end
            3'd6: begin btype_new = 2'b10; blen_new = 5'd16; end
            default: begin btype_new = 2'b01; blen_new = 5'd16; end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        addr_d         = addr_q;
        strobe_d       = strobe_q;
        is_burst_d     = is_burst_q;
        burst_type_d   = burst_type_q;
        burst_length_d = burst_length_q;
        HREADYOUT      = 1'b1;
        HRESP          = 1'b0;
        wen            = 1'b0;
        ren            = 1'b0;
        take           = 1'b0;
        case (state_q)
            IDLE: take = accept;
            ACCESS: begin
                wen = write_q;
                ren = !write_q;
                if (bpif.request_stall) begin
                    HREADYOUT = 1'b0;
                end else if (bpif.error) begin
                    HREADYOUT = 1'b0;
                    HRESP     = 1'b1;
                    state_d   = ERR1;
                end else begin
                    take    = accept;
                    state_d = IDLE;
                end
            end
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ERR2;
            end
            ERR2: begin
                HRESP   = 1'b1;
                take    = accept;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // An illegal beat never reaches the peripheral; only legal beats update the latches.
        if (take) begin
            if (legal) begin
                state_d        = ACCESS;
                write_d        = HWRITE;
                addr_d         = HADDR;
                strobe_d       = strb_new;
                is_burst_d     = (HBURST != 3'd0);
                burst_type_d   = btype_new;
                burst_length_d = blen_new;
            end else begin
                state_d = ERR1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= IDLE;
            write_q        <= 1'b0;
            addr_q         <= '0;
            strobe_q       <= '0;
            is_burst_q     <= 1'b0;
            burst_type_q   <= 2'b00;
            burst_length_q <= 5'd0;
        end else begin
            state_q        <= state_d;
            write_q        <= write_d;
            addr_q         <= addr_d;
            strobe_q       <= strobe_d;
            is_burst_q     <= is_burst_d;
            burst_type_q   <= burst_type_d;
            burst_length_q <= burst_length_d;
        end
    end

    assign HRDATA               = ren ? bpif.rdata : '0;
    assign bpif.wen             = wen;
    assign bpif.ren             = ren;
    assign bpif.addr            = addr_q;
    assign bpif.wdata           = wen ? HWDATA : '0;
    assign bpif.strobe          = strobe_q;
    assign bpif.is_burst        = is_burst_q;
    assign bpif.burst_type      = burst_type_q;
    assign bpif.burst_length    = burst_length_q;
    assign bpif.secure_transfer = 1'b0;

endmodule

// File: tb/tb_ahb_lite_subordinate_bpif.sv
// Directed bench for the AHB-Lite subordinate: single-subordinate bus, HREADY fed back from HREADYOUT.
module tb_ahb_lite_subordinate_bpif;
    logic        CLK, nRST, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    int          vectors = 0;
    int          miscompares = 0;

    bus_protocol_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bpif ();

    ahb_lite_subordinate_bpif #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .CLK(CLK), .nRST(nRST), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .bpif(bpif.protocol)
    );

    assign HREADY = HREADYOUT;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [2:0] bu, input logic [1:0] tr);
        HSEL = 1'b1; HADDR = a; HWRITE = w; HSIZE = sz; HBURST = bu; HTRANS = tr;
    endtask

    task automatic idle_bus();
        HTRANS = 2'b00; HSEL = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; idle_bus(); HADDR = '0; HWRITE = 1'b0; HSIZE = '0; HBURST = '0; HWDATA = '0;
        bpif.request_stall = 1'b0; bpif.error = 1'b0; bpif.rdata = '0;
        @(negedge CLK);
        vectors++;
        if ({HREADYOUT, HRESP, bpif.wen, bpif.ren} !== 4'b1000) begin
            miscompares++; $display("FAIL reset_ctrl got %b want 1000", {HREADYOUT, HRESP, bpif.wen, bpif.ren});
        end
        vectors++;
        if ({HRDATA, bpif.addr, bpif.strobe, bpif.is_burst, bpif.burst_type, bpif.burst_length} !== '0) begin
            miscompares++; $display("FAIL reset_data got rdata=%h addr=%h strobe=%b hints=%b%b%0d", HRDATA,
                                    bpif.addr, bpif.strobe, bpif.is_burst, bpif.burst_type, bpif.burst_length);
        end
        @(negedge CLK); nRST = 1'b1;
        tick();
    endtask

    task automatic test_write();
        addr_phase(32'h10, 1'b1, 3'd2, 3'd0, 2'b10);
        tick();
        idle_bus(); HWDATA = 32'hDEADBEEF;   // HSEL drop in the data phase must not cancel the beat
        @(negedge CLK);
        vectors++;
        if ({HREADYOUT, HRESP, bpif.wen, bpif.ren} !== 4'b1010) begin
            miscompares++; $display("FAIL write_ctrl got %b want 1010", {HREADYOUT, HRESP, bpif.wen, bpif.ren});
        end
        vectors++;
        if (bpif.addr !== 32'h10 || bpif.strobe !== 4'hF || bpif.wdata !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL write_beat got addr=%h strobe=%b wdata=%h want 10 1111 deadbeef",
                                    bpif.addr, bpif.strobe, bpif.wdata);
        end
        tick();
        @(negedge CLK);
        vectors++;
        if ({HREADYOUT, HRESP, bpif.wen, bpif.ren} !== 4'b1000) begin
            miscompares++; $display("FAIL write_done got %b want 1000", {HREADYOUT, HRESP, bpif.wen, bpif.ren});
        end
    endtask

    task automatic test_read_stall();
        logic [2:0] exp_rdy;
        exp_rdy = 3'b001;
        addr_phase(32'h04, 1'b0, 3'd2, 3'd0, 2'b10);
        tick();
        idle_bus(); bpif.request_stall = 1'b1; bpif.rdata = 32'hCAFE0001;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) bpif.request_stall = 1'b0;
            @(negedge CLK);
            vectors++;
            if (HREADYOUT !== exp_rdy[2-c] || bpif.ren !== 1'b1 || bpif.wen !== 1'b0 || bpif.addr !== 32'h04) begin
                miscompares++; $display("FAIL read_stall_c%0d got rdy=%b ren=%b wen=%b addr=%h want %b 1 0 04",
                                        c, HREADYOUT, bpif.ren, bpif.wen, bpif.addr, exp_rdy[2-c]);
            end
            if (c < 2) tick();
        end
        vectors++;
        if (HRDATA !== 32'hCAFE0001) begin
            miscompares++; $display("FAIL read_data got %h want cafe0001", HRDATA);
        end
        tick();
        @(negedge CLK);
        vectors++;
        if (bpif.ren !== 1'b0 || HRDATA !== 32'h0) begin
            miscompares++; $display("FAIL read_done got ren=%b rdata=%h want 0 0", bpif.ren, HRDATA);
        end
    endtask

    task automatic test_strobe();
        addr_phase(32'h13, 1'b1, 3'd0, 3'd0, 2'b10);
        tick();
        HWDATA = 32'hAB000000;
        addr_phase(32'h02, 1'b1, 3'd1, 3'd0, 2'b10);
        @(negedge CLK);
        vectors++;
        if (bpif.wen !== 1'b1 || bpif.strobe !== 4'b1000 || bpif.wdata !== 32'hAB000000) begin
            miscompares++; $display("FAIL strobe_byte got wen=%b strobe=%b wdata=%h want 1 1000 ab000000",
                                    bpif.wen, bpif.strobe, bpif.wdata);
        end
        tick();
        idle_bus(); HWDATA = 32'h1234_0000;
        @(negedge CLK);
        vectors++;
        if (bpif.wen !== 1'b1 || bpif.strobe !== 4'b1100 || bpif.addr !== 32'h02) begin
            miscompares++; $display("FAIL strobe_half got wen=%b strobe=%b addr=%h want 1 1100 02",
                                    bpif.wen, bpif.strobe, bpif.addr);
        end
        tick();
    endtask

    task automatic test_error();
        logic [3:0] exp [4];
        exp[0] = 4'b0101; exp[1] = 4'b0100; exp[2] = 4'b1100; exp[3] = 4'b1000;
        addr_phase(32'h20, 1'b0, 3'd2, 3'd0, 2'b10);
        tick();
        idle_bus(); bpif.error = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            vectors++;
            if ({HREADYOUT, HRESP, bpif.wen, bpif.ren} !== exp[c]) begin
                miscompares++; $display("FAIL periph_err_c%0d got %b want %b", c,
                                        {HREADYOUT, HRESP, bpif.wen, bpif.ren}, exp[c]);
            end
            tick();
            bpif.error = 1'b0;
        end
    endtask

    task automatic test_illegal();
        // word @0x02, then HSIZE=3 accepted in ERR2, then a legal read accepted in ERR2
        logic [3:0] exp [5];
        exp[0] = 4'b0100; exp[1] = 4'b1100; exp[2] = 4'b0100; exp[3] = 4'b1100; exp[4] = 4'b1001;
        addr_phase(32'h02, 1'b1, 3'd2, 3'd0, 2'b10);
        @(negedge CLK);
        vectors++;
        if ({HREADYOUT, HRESP, bpif.wen, bpif.ren} !== 4'b1000) begin
            miscompares++; $display("FAIL illegal_accept got %b want 1000", {HREADYOUT, HRESP, bpif.wen, bpif.ren});
        end
        tick();
        idle_bus();
        for (int c = 0; c < 5; c++) begin
            if (c == 1) addr_phase(32'h00, 1'b0, 3'd3, 3'd0, 2'b10);
            if (c == 3) addr_phase(32'h08, 1'b0, 3'd2, 3'd0, 2'b10);
            @(negedge CLK);
            vectors++;
            if ({HREADYOUT, HRESP, bpif.wen, bpif.ren} !== exp[c]) begin
                miscompares++; $display("FAIL illegal_c%0d got %b want %b", c,
                                        {HREADYOUT, HRESP, bpif.wen, bpif.ren}, exp[c]);
            end
            tick();
            idle_bus();
        end
        @(negedge CLK);
        vectors++;
        if ({HREADYOUT, HRESP, bpif.wen, bpif.ren} !== 4'b1000) begin
            miscompares++; $display("FAIL illegal_idle got %b want 1000", {HREADYOUT, HRESP, bpif.wen, bpif.ren});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd [4];
        rd[1] = 32'h1111_2222; rd[3] = 32'h3333_4444;
        addr_phase(32'h40, 1'b1, 3'd2, 3'd3, 2'b10);
        tick();
        for (int i = 1; i <= 4; i++) begin
            HWDATA = 32'hA000_0000 + 32'(i);
            bpif.rdata = (i % 2 == 0) ? rd[i-1] : 32'h0;
            if (i < 4) addr_phase(32'h40 + 32'(4 * i), (i % 2 == 0), 3'd2, 3'd3, 2'b11);
            else idle_bus();
            @(negedge CLK);
            vectors++;
            if (HREADYOUT !== 1'b1 || bpif.wen !== (i % 2 == 1) || bpif.ren !== (i % 2 == 0) ||
                bpif.addr !== 32'h40 + 32'(4 * (i - 1))) begin
                miscompares++; $display("FAIL b2b_beat%0d got rdy=%b wen=%b ren=%b addr=%h", i - 1,
                                        HREADYOUT, bpif.wen, bpif.ren, bpif.addr);
            end
            vectors++;
            if (bpif.is_burst !== 1'b1 || bpif.burst_type !== 2'b01 || bpif.burst_length !== 5'd4 ||
                bpif.secure_transfer !== 1'b0) begin
                miscompares++; $display("FAIL b2b_hints%0d got %b %b %0d %b want 1 01 4 0", i - 1,
                                        bpif.is_burst, bpif.burst_type, bpif.burst_length, bpif.secure_transfer);
            end
            vectors++;
            if (HRDATA !== ((i % 2 == 0) ? rd[i-1] : 32'h0)) begin
                miscompares++; $display("FAIL b2b_rdata%0d got %h", i - 1, HRDATA);
            end
            tick();
        end
        @(negedge CLK);
        vectors++;
        if ({bpif.wen, bpif.ren} !== 2'b00) begin
            miscompares++; $display("FAIL b2b_idle got %b want 00", {bpif.wen, bpif.ren});
        end
    endtask

    task automatic test_reset_stall();
        addr_phase(32'h0C, 1'b0, 3'd2, 3'd5, 2'b10);
        tick();
        idle_bus(); bpif.request_stall = 1'b1; bpif.rdata = 32'h5555AAAA;
        @(negedge CLK);
        vectors++;
        if (HREADYOUT !== 1'b0 || bpif.ren !== 1'b1 || HRDATA !== 32'h5555AAAA) begin
            miscompares++; $display("FAIL rst_stall_pre got rdy=%b ren=%b rdata=%h", HREADYOUT, bpif.ren, HRDATA);
        end
        #1 nRST = 1'b0;
        #1;
        vectors++;
        if ({HREADYOUT, HRESP, bpif.wen, bpif.ren} !== 4'b1000 || HRDATA !== 32'h0 ||
            bpif.addr !== 32'h0 || bpif.strobe !== 4'h0 || bpif.is_burst !== 1'b0 || bpif.burst_length !== 5'd0) begin
            miscompares++; $display("FAIL rst_stall got ctrl=%b rdata=%h addr=%h strobe=%b burst=%b/%0d",
                                    {HREADYOUT, HRESP, bpif.wen, bpif.ren}, HRDATA, bpif.addr, bpif.strobe,
                                    bpif.is_burst, bpif.burst_length);
        end
        bpif.request_stall = 1'b0;
        @(negedge CLK); nRST = 1'b1;
        tick();
        @(negedge CLK);
        vectors++;
        if ({HREADYOUT, HRESP, bpif.wen, bpif.ren} !== 4'b1000) begin
            miscompares++; $display("FAIL rst_stall_after got %b want 1000", {HREADYOUT, HRESP, bpif.wen, bpif.ren});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_strobe();
        test_error();
        test_illegal();
        test_back_to_back();
        test_reset_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
